// File: rtl/astable_timer_ctrl.sv
// astable_timer_ctrl: clock-accurate 555-style astable pulse sequencer.
// Programmable OFF/ON durations in cycles, start/stop control, busy/done
// status and a saturating completed-pulse counter.
// Optional feature: define ASTABLE_BURST_EN to add the burst_len port and
// finite bursts terminated by a one-cycle done strobe. Without it the block
// free-runs until stop and done is tied low.
module astable_timer_ctrl #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned BURST_W = 8,
    parameter int unsigned DEF_ON  = 353,
    parameter int unsigned DEF_OFF = 346
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_we,
    input  logic [CNT_W-1:0]   cfg_on,
    input  logic [CNT_W-1:0]   cfg_off,
    input  logic               start,
    input  logic               stop,
`ifdef ASTABLE_BURST_EN
    input  logic [BURST_W-1:0] burst_len,
`endif
    output logic               pulse,
    output logic               busy,
    output logic               done,
    output logic [BURST_W-1:0] pulse_cnt
);

    localparam int unsigned BW1 = BURST_W + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OFF  = 2'd1,
        S_ON   = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [CNT_W-1:0]   on_q,    on_d;
    logic [CNT_W-1:0]   off_q,   off_d;
    logic [BURST_W-1:0] pcnt_q,  pcnt_d;
    logic               start_q;
    logic               pulse_q;
    logic               busy_q;
`ifdef ASTABLE_BURST_EN
    logic [BURST_W-1:0] burst_q, burst_d;
    logic               done_q;
`endif

    // Next-state, counter, configuration and pulse-count logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        on_d    = on_q;
        off_d   = off_q;
        pcnt_d  = pcnt_q;
`ifdef ASTABLE_BURST_EN
        burst_d = burst_q;
`endif
        // Durations are only writable while idle; zero is clamped to one cycle.
        if (state_q == S_IDLE && cfg_we) begin
            on_d  = (cfg_on  == '0) ? CNT_W'(1) : cfg_on;
            off_d = (cfg_off == '0) ? CNT_W'(1) : cfg_off;
        end
        if (stop) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_q) begin
                        state_d = S_OFF;
                        cnt_d   = off_q - CNT_W'(1);
                        pcnt_d  = '0;
`ifdef ASTABLE_BURST_EN
                        burst_d = burst_len;
`endif
                    end
                end
                S_OFF: begin
                    if (cnt_q == '0) begin
                        state_d = S_ON;
                        cnt_d   = on_q - CNT_W'(1);
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_ON: begin
                    if (cnt_q == '0) begin
                        if (pcnt_q != '1) begin
                            pcnt_d = pcnt_q + BURST_W'(1);
                        end
                        state_d = S_OFF;
                        cnt_d   = off_q - CNT_W'(1);
`ifdef ASTABLE_BURST_EN
                        if (burst_q != '0 &&
                            (BW1'(pcnt_q) + BW1'(1)) == BW1'(burst_q)) begin
                            state_d = S_DONE;
                            cnt_d   = '0;
                        end
`endif
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State, counters and registered outputs; start is captured one cycle
    // ahead of the FSM, and a concurrent stop cancels it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            on_q    <= CNT_W'(DEF_ON);
            off_q   <= CNT_W'(DEF_OFF);
            pcnt_q  <= '0;
            start_q <= 1'b0;
            pulse_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef ASTABLE_BURST_EN
            burst_q <= '0;
            done_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            on_q    <= on_d;
            off_q   <= off_d;
            pcnt_q  <= pcnt_d;
            start_q <= start & ~stop;
            pulse_q <= (state_d == S_ON);
            busy_q  <= (state_d == S_OFF) || (state_d == S_ON);
`ifdef ASTABLE_BURST_EN
            burst_q <= burst_d;
            done_q  <= (state_d == S_DONE);
`endif
        end
    end

    assign pulse     = pulse_q;
    assign busy      = busy_q;
    assign pulse_cnt = pcnt_q;
`ifdef ASTABLE_BURST_EN
    assign done      = done_q;
`else
    assign done      = 1'b0;
`endif

endmodule

// File: tb/tb_astable_timer_ctrl.sv
// Directed self-checking bench for astable_timer_ctrl.
// Burst scenarios run when ASTABLE_BURST_EN is defined.
module tb_astable_timer_ctrl;

    logic        clk;
    logic        rst_n;
    logic        cfg_we;
    logic [15:0] cfg_on;
    logic [15:0] cfg_off;
    logic        start;
    logic        stop;
`ifdef ASTABLE_BURST_EN
    logic [7:0]  burst_len;
`endif
    logic        pulse;
    logic        busy;
    logic        done;
    logic [7:0]  pulse_cnt;

    int n_checks;
    int n_err;

    astable_timer_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_on    (cfg_on),
        .cfg_off   (cfg_off),
        .start     (start),
        .stop      (stop),
`ifdef ASTABLE_BURST_EN
        .burst_len (burst_len),
`endif
        .pulse     (pulse),
        .busy      (busy),
        .done      (done),
        .pulse_cnt (pulse_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Expected waveform k edges after the start-sampling edge:
    // phase p = k-1 cycles into the run; high when p mod period >= off.
    task automatic run_check(input int on, input int off, input int k0, input int k1,
                             input string tag);
        int per;
        int ph;
        int cnt;
        per = on + off;
        for (int k = k0; k <= k1; k++) begin
            tick(1);
            ph  = k - 1;
            cnt = ph / per;
            if (cnt > 255) cnt = 255;
            chk({tag, ".pulse"}, 32'(pulse), 32'((ph % per) >= off));
            chk({tag, ".busy"},  32'(busy), 32'd1);
            chk({tag, ".cnt"},   32'(pulse_cnt), 32'(cnt));
            chk({tag, ".done"},  32'(done), 32'd0);
        end
    endtask

    task automatic start_run();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic write_cfg(input logic [15:0] on, input logic [15:0] off);
        cfg_on  = on;
        cfg_off = off;
        cfg_we  = 1'b1;
        tick(1);
        cfg_we  = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        cfg_we   = 1'b0;
        cfg_on   = 16'd0;
        cfg_off  = 16'd0;
        start    = 1'b0;
        stop     = 1'b0;
`ifdef ASTABLE_BURST_EN
        burst_len = 8'd0;
`endif
        tick(2);
        chk("rst.pulse", 32'(pulse), 32'd0);
        chk("rst.busy",  32'(busy), 32'd0);
        chk("rst.done",  32'(done), 32'd0);
        chk("rst.cnt",   32'(pulse_cnt), 32'd0);
        #2 rst_n = 1'b1;
        tick(2);
        chk("idle.busy", 32'(busy), 32'd0);

        // Default durations: rise 347 after start edge, high 353, period 699.
        start_run();
        chk("def.busy0", 32'(busy), 32'd0);
        run_check(353, 346, 1, 1050, "def");
        do_stop();
        chk("def.stop.pulse", 32'(pulse), 32'd0);
        chk("def.stop.busy",  32'(busy), 32'd0);
        chk("def.stop.cnt",   32'(pulse_cnt), 32'd1);

        // Reprogram on=3 off=2; mid-run write must not alter timing.
        write_cfg(16'd3, 16'd2);
        start_run();
        run_check(3, 2, 1, 7, "rp");
        cfg_on  = 16'd9;
        cfg_we  = 1'b1;
        run_check(3, 2, 8, 13, "rp.we");
        cfg_we  = 1'b0;
        chk("rp.onphase", 32'(pulse), 32'd1);
        // Abort in the middle of an ON phase.
        do_stop();
        chk("abort.pulse", 32'(pulse), 32'd0);
        chk("abort.busy",  32'(busy), 32'd0);
        chk("abort.done",  32'(done), 32'd0);
        chk("abort.cnt",   32'(pulse_cnt), 32'd2);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("abort.idle.busy", 32'(busy), 32'd0);
            chk("abort.idle.done", 32'(done), 32'd0);
        end

        // Start and stop together in IDLE: stays idle.
        start = 1'b1;
        stop  = 1'b1;
        tick(1);
        start = 1'b0;
        stop  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("ss.busy",  32'(busy), 32'd0);
            chk("ss.pulse", 32'(pulse), 32'd0);
        end

        // Zero clamp: on=0/off=0 behaves as 1/1, period 2.
        write_cfg(16'd0, 16'd0);
        start_run();
        run_check(1, 1, 1, 12, "zc");
        do_stop();

`ifdef ASTABLE_BURST_EN
        // Burst of 3 pulses with on=2 off=2.
        write_cfg(16'd2, 16'd2);
        burst_len = 8'd3;
        start_run();
        run_check(2, 2, 1, 12, "bu");
        tick(1);
        chk("bu.done",  32'(done), 32'd1);
        chk("bu.busy",  32'(busy), 32'd0);
        chk("bu.pulse", 32'(pulse), 32'd0);
        chk("bu.cnt",   32'(pulse_cnt), 32'd3);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            chk("bu.after.done",  32'(done), 32'd0);
            chk("bu.after.busy",  32'(busy), 32'd0);
            chk("bu.after.pulse", 32'(pulse), 32'd0);
            chk("bu.after.cnt",   32'(pulse_cnt), 32'd3);
        end
        // burst_len=0 free-runs past 10 pulses.
        burst_len = 8'd0;
        start_run();
        run_check(2, 2, 1, 46, "fr");
        chk("fr.cnt11", 32'(pulse_cnt), 32'd11);
        do_stop();
`endif

        // Asynchronous reset during ON without a clock edge.
        write_cfg(16'd5, 16'd5);
        start_run();
        run_check(5, 5, 1, 17, "ar");
        chk("ar.pre.pulse", 32'(pulse), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar.pulse", 32'(pulse), 32'd0);
        chk("ar.busy",  32'(busy), 32'd0);
        chk("ar.cnt",   32'(pulse_cnt), 32'd0);
        chk("ar.done",  32'(done), 32'd0);
        #1 rst_n = 1'b1;
        tick(1);
        start_run();
        run_check(353, 346, 1, 360, "ar.def");
        do_stop();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
